// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding byte/half/word access to a word-wide,
// combinational-read data memory; sub-word stores use read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        bad;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign bad = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   byte_v = mem_rdata[15:8];
      2'b10:   byte_v = mem_rdata[23:16];
      2'b11:   byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   ld_ext = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: ld_ext = mem_rdata;
    endcase
    // only the addressed lane is replaced; the rest of the word is written back as read
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 16'h0;
      wword_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata[15:0];
          rdata_q <= 32'h0;
          err_q   <= bad;
          if (bad)                     state <= RESP;
          else if (!req_we)            state <= LOAD;
          else if (req_size == 2'b10) begin
            wword_q <= req_wdata;
            state   <= WRITE;
          end else                     state <= MERGE;
        end
        LOAD: begin
          rdata_q <= ld_ext;
          state   <= RESP;
        end
        MERGE: begin
          wword_q <= merged;
          state   <= WRITE;
        end
        WRITE: state <= RESP;
        RESP:  if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_addr  = {2'b00, addr_q[31:2]};
  assign mem_we    = (state == WRITE);
  assign mem_wdata = wword_q;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector table plus backpressure and mid-operation reset sequences
// against a single-word memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // single-word memory: one tracked word, everything else reads as a marker
  logic [31:0] mword = 32'h0, mword_idx = 32'h0;
  logic [31:0] ld_idx = 32'h0, ld_val = 32'h0;
  logic        ld_en = 1'b0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;
  int          wr_cnt = 0;

  assign mem_rdata = (mem_addr == mword_idx) ? mword : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (ld_en) begin
      mword_idx <= ld_idx;
      mword     <= ld_val;
    end else if (mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
      if (mem_addr == mword_idx) mword <= mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, init, exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_wr;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] init, logic [31:0] exp_rdata,
                              logic exp_err, int exp_lat, int exp_wr, logic [31:0] exp_word);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.init = init;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    v.exp_word = exp_word;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] idx, input logic [31:0] val);
    ld_idx = idx; ld_val = val; ld_en = 1'b1;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  // issue one request, scramble req_* after accept, wait for rsp_valid
  task automatic run_req(input vec_t v, output int lat, output int nwr, output int we_cyc);
    int w0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size; req_unsigned = ~v.uns;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; we_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) we_cyc = c;
      if (rsp_valid) begin lat = c; break; end
    end
    nwr = wr_cnt - w0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  vec_t vt[15];

  initial begin
    int lat, nwr, we_cyc, w0, seen;
    vt[0]  = mk(0, 2'b00, 0, 32'h282, 32'h0, 32'h8081F2F3, 32'hFFFFFF81, 0, 2, 0, 32'h8081F2F3);
    vt[1]  = mk(0, 2'b01, 1, 32'h280, 32'h0, 32'h8081F2F3, 32'h0000F2F3, 0, 2, 0, 32'h8081F2F3);
    vt[2]  = mk(0, 2'b01, 0, 32'h282, 32'h0, 32'h8081F2F3, 32'hFFFF8081, 0, 2, 0, 32'h8081F2F3);
    vt[3]  = mk(0, 2'b00, 1, 32'h283, 32'h0, 32'h8081F2F3, 32'h00000080, 0, 2, 0, 32'h8081F2F3);
    vt[4]  = mk(0, 2'b10, 0, 32'h280, 32'h0, 32'h8081F2F3, 32'h8081F2F3, 0, 2, 0, 32'h8081F2F3);
    vt[5]  = mk(0, 2'b00, 0, 32'h280, 32'h0, 32'h8081F2F3, 32'hFFFFFFF3, 0, 2, 0, 32'h8081F2F3);
    vt[6]  = mk(1, 2'b00, 0, 32'h281, 32'hAABBCC55, 32'h11223344, 32'h0, 0, 3, 1, 32'h11225544);
    vt[7]  = mk(1, 2'b01, 0, 32'h12, 32'h1234BEEF, 32'h11223344, 32'h0, 0, 3, 1, 32'hBEEF3344);
    vt[8]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h0, 0, 2, 1, 32'hDEADBEEF);
    vt[9]  = mk(0, 2'b01, 0, 32'h3, 32'h0, 32'h11111111, 32'h0, 1, 1, 0, 32'h11111111);
    vt[10] = mk(1, 2'b10, 0, 32'h6, 32'h12345678, 32'h22222222, 32'h0, 1, 1, 0, 32'h22222222);
    vt[11] = mk(0, 2'b11, 0, 32'h0, 32'h0, 32'h44444444, 32'h0, 1, 1, 0, 32'h44444444);
    vt[12] = mk(1, 2'b00, 0, 32'hFFFFFFFF, 32'h000000A5, 32'h01020304, 32'h0, 0, 3, 1, 32'hA5020304);
    vt[13] = mk(1, 2'b11, 0, 32'h8, 32'hFFFFFFFF, 32'h33333333, 32'h0, 1, 1, 0, 32'h33333333);
    vt[14] = mk(0, 2'b00, 1, 32'hFFFFFFFE, 32'h0, 32'h7F6E5D4C, 32'h0000006E, 0, 2, 0, 32'h7F6E5D4C);

    // reset values, before any clock edge
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      preload({2'b00, vt[i].addr[31:2]}, vt[i].init);
      run_req(vt[i], lat, nwr, we_cyc);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_nwr", i), 32'(nwr), 32'(vt[i].exp_wr));
      chk($sformatf("v%0d_word", i), mword, vt[i].exp_word);
      if (vt[i].exp_wr != 0) begin
        chk($sformatf("v%0d_we_cyc", i), 32'(we_cyc), 32'(vt[i].exp_lat - 1));
        chk($sformatf("v%0d_waddr", i), last_wa, {2'b00, vt[i].addr[31:2]});
        chk($sformatf("v%0d_wdata", i), last_wd, vt[i].exp_word);
      end
      finish_rsp();
    end

    // backpressure: 5 stalled cycles in RESP, then no accept on the exit edge
    preload(32'hA0, 32'h8081F2F3);
    run_req(vt[0], lat, nwr, we_cyc);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hFFFFFF81);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h280;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_exit_req_ready", 32'(req_ready), 32'd1);
    chk("bp_exit_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_no_accept", 32'(rsp_valid), 32'd0);

    // reset during MERGE of a halfword store
    preload(32'h5, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h00001234;
    w0 = wr_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mr_merge_no_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_mem_we", 32'(mem_we), 32'd0);
    chk("mr_mem_addr", mem_addr, 32'h0);
    chk("mr_mem_wdata", mem_wdata, 32'h0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_rdata", rsp_rdata, 32'h0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) seen++;
    end
    chk("mr_no_activity", 32'(seen), 32'd0);
    chk("mr_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("mr_word_kept", mword, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
